// File: rtl/cla_16_bit_lookahead.sv
// 16-bit two-level carry-lookahead adder: four 4-bit CLA groups under a flat second-level unit.
// One-cycle latency, a new operand set every cycle, no handshake; exports block P/G for cascading.
module cla_16_bit_lookahead (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout,
  output logic        pout,
  output logic        gout
);

  logic [15:0] p, g, c;
  logic [3:0]  gp, gg;
  logic [4:0]  gc;
  logic [15:0] sum_d, sum_q;
  logic        cout_d, cout_q;
  logic        pout_d, pout_q;
  logic        gout_d, gout_q;

  always_comb begin
    p  = a ^ b;
    g  = a & b;
    gp = '0;
    gg = '0;
    gc = '0;
    c  = '0;

    for (int k = 0; k < 4; k++) begin
      gp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end

    // Group carries are flat sums of products; none is built from another.
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end

    sum_d  = p ^ c;
    cout_d = gc[4];
    pout_d = &gp;
    gout_d = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
           | (gp[3] & gp[2] & gp[1] & gg[0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= 16'h0000;
      cout_q <= 1'b0;
      pout_q <= 1'b0;
      gout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      pout_q <= pout_d;
      gout_q <= gout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign pout = pout_q;
  assign gout = gout_q;

endmodule

// File: tb/tb_cla_16_bit_lookahead.sv
// Directed and random checks of the registered 16-bit lookahead adder.
module tb_cla_16_bit_lookahead;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic        cin;
  logic [15:0] sum;
  logic        cout, pout, gout;

  int n_asserts = 0;
  int n_fail    = 0;

  cla_16_bit_lookahead dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout),
    .pout (pout),
    .gout (gout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one operand set, clock it in, sample 1 time unit after the edge.
  task automatic step(input logic r, input logic [15:0] av, input logic [15:0] bv, input logic ci);
    rst = r; a = av; b = bv; cin = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [15:0] es, input logic ec,
                         input logic ep, input logic eg);
    chk({tag, ".sum"},  sum, es);
    chk({tag, ".cout"}, {15'd0, cout}, {15'd0, ec});
    chk({tag, ".pout"}, {15'd0, pout}, {15'd0, ep});
    chk({tag, ".gout"}, {15'd0, gout}, {15'd0, eg});
  endtask

  initial begin
    logic [16:0] full;
    logic [16:0] gen;
    logic [15:0] ra, rb;
    logic        rc;

    rst = 1'b1; a = 16'h0; b = 16'h0; cin = 1'b0;
    #2;

    // Reset with live-looking operands must still clear the outputs.
    step(1'b1, 16'h1234, 16'hFFFF, 1'b1);
    chk_all("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hFFFF, 16'h0000, 1'b1);
    chk_all("reset_hold", 16'h0000, 1'b0, 1'b0, 1'b0);

    step(1'b0, 16'hFF3F, 16'h5555, 1'b0);
    chk_all("ff3f_5555", 16'h5494, 1'b1, 1'b0, 1'b1);

    step(1'b0, 16'hFFFF, 16'h0000, 1'b1);
    chk_all("ffff_0_c1", 16'h0000, 1'b1, 1'b1, 1'b0);

    step(1'b0, 16'hFFFF, 16'h0000, 1'b0);
    chk_all("ffff_0_c0", 16'hFFFF, 1'b0, 1'b1, 1'b0);

    step(1'b0, 16'h8000, 16'h8000, 1'b0);
    chk_all("8000_8000", 16'h0000, 1'b1, 1'b0, 1'b1);

    step(1'b0, 16'h000F, 16'h0001, 1'b0);
    chk_all("group_carry", 16'h0010, 1'b0, 1'b0, 1'b0);

    // Back-to-back operand sets on consecutive edges.
    step(1'b0, 16'h0001, 16'h0001, 1'b0);
    chk_all("b2b_0", 16'h0002, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    chk_all("b2b_1", 16'h8000, 1'b0, 1'b0, 1'b0);

    step(1'b0, 16'h1234, 16'h4321, 1'b1);
    chk_all("pre_rst", 16'h5556, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
    chk_all("mid_rst", 16'h0000, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      gen  = {1'b0, ra} + {1'b0, rb};
      step(1'b0, ra, rb, rc);
      chk_all("rand", full[15:0], full[16], (ra ^ rb) == 16'hFFFF, gen[16]);
      chk("rand.invariant", {15'd0, cout}, {15'd0, gout | (pout & rc)});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
